// File: rtl/sp_ram_req_bridge.sv
// Core data-port to single-port RAM bridge: range-checks each request, drives RAM strobes, returns one in-order response per grant.
// Latency: grant in cycle T -> response valid in T+1 when nothing is queued ahead; one transaction per cycle when r_ready=1.
// Backpressure: at most two responses outstanding (pending beat + 2-entry FIFO); gnt_o drops until a response is popped.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   req_i/gnt_o, addr_i, we_i, be_i,   request channel (grant is combinational)
//   wdata_i
//   r_valid_o/r_ready_i, r_rdata_o,    response channel; rdata is 0 for writes and errors
//   r_err_o
//   ram_en_o, ram_addr_o, ram_we_o,    RAM strobes (combinational from the request)
//   ram_be_o, ram_wdata_o, ram_rdata_i RAM read data arrives one cycle after ram_en_o
module sp_ram_req_bridge #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_WORDS  = 4096,
  parameter logic [31:0] BASE_ADDR  = 32'h0010_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [31:0]             addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [DATA_WIDTH-1:0]   r_rdata_o,
  output logic                    r_err_o,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  localparam logic [32:0] WINDOW = 33'(NUM_WORDS);

  // ---------------- address decode ----------------
  logic [31:0] off;
  logic        oob;

  // Addresses below BASE_ADDR wrap to a huge offset and fall out of range.
  assign off = addr_i - BASE_ADDR;
  assign oob = ({1'b0, off} >= WINDOW);

  // ---------------- state ----------------
  logic                  pend_q;
  logic                  pend_we_q;
  logic                  pend_err_q;

  logic [DATA_WIDTH-1:0] fifo_rdata [2];
  logic                  fifo_err   [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            fifo_cnt_q;

  // ---------------- credit / grant ----------------
  logic [1:0] occ;
  logic       fifo_empty;
  logic       pop;
  logic       fifo_push;
  logic       fifo_pop;

  assign occ        = fifo_cnt_q + {1'b0, pend_q};
  assign fifo_empty = (fifo_cnt_q == 2'd0);
  assign pop        = r_valid_o & r_ready_i;

  // A pop in the same cycle frees a slot, so a full bridge can still accept.
  // rst_n gating keeps the grant low for the whole reset window.
  assign gnt_o = rst_n & req_i & ((occ < 2'd2) | pop);

  // ---------------- RAM drive ----------------
  assign ram_en_o    = gnt_o & ~oob;
  assign ram_addr_o  = off[ADDR_WIDTH-1:0];
  assign ram_we_o    = we_i;
  assign ram_be_o    = be_i;
  assign ram_wdata_o = wdata_i;

  // ---------------- pending beat ----------------
  logic [DATA_WIDTH-1:0] pend_rdata;

  assign pend_rdata = (pend_we_q | pend_err_q) ? '0 : ram_rdata_i;

  // The pending beat goes straight out when nothing is queued ahead; if the
  // consumer is not ready it is parked in the FIFO so ram_rdata_i (valid for
  // only one cycle) is captured and the outputs stay stable.
  assign fifo_push = pend_q & ~(fifo_empty & r_ready_i);
  assign fifo_pop  = ~fifo_empty & r_ready_i;

  always_comb begin
    r_valid_o = 1'b0;
    r_rdata_o = '0;
    r_err_o   = 1'b0;
    if (!fifo_empty) begin
      r_valid_o = 1'b1;
      r_rdata_o = fifo_rdata[rd_ptr_q];
      r_err_o   = fifo_err[rd_ptr_q];
    end else if (pend_q) begin
      r_valid_o = 1'b1;
      r_rdata_o = pend_rdata;
      r_err_o   = pend_err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= 1'b0;
      pend_we_q  <= 1'b0;
      pend_err_q <= 1'b0;
    end else begin
      pend_q <= gnt_o;
      if (gnt_o) begin
        pend_we_q  <= we_i;
        pend_err_q <= oob;
      end
    end
  end

  // ---------------- response FIFO ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (fifo_push) wr_ptr_q <= ~wr_ptr_q;
      if (fifo_pop)  rd_ptr_q <= ~rd_ptr_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
    end
  end

  // Storage needs no reset: entries are only read when fifo_cnt_q says valid.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_rdata[wr_ptr_q] <= pend_rdata;
      fifo_err[wr_ptr_q]   <= pend_err_q;
    end
  end

endmodule

// File: tb/tb_sp_ram_req_bridge.sv
module tb_sp_ram_req_bridge;

  localparam logic [31:0] BASE = 32'h0010_0000;
  localparam int          NW   = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic        r_ready = 1'b0;

  logic        gnt_o, r_valid_o, r_err_o, ram_en_o, ram_we_o;
  logic [31:0] r_rdata_o, ram_wdata_o;
  logic [11:0] ram_addr_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_rdata = '0;

  sp_ram_req_bridge #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_WORDS(NW), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req), .gnt_o(gnt_o), .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready), .r_rdata_o(r_rdata_o), .r_err_o(r_err_o),
    .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- RAM environment (registered read) ----------------
  logic [31:0] ram_mem [1024];
  int          en_cnt = 0;

  always @(posedge clk) begin
    if (ram_en_o) begin
      en_cnt++;
      if (ram_we_o)
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b]) ram_mem[ram_addr_o[11:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      ram_rdata <= ram_mem[ram_addr_o[11:2]];
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed { logic [31:0] d; logic e; } resp_t;

  logic [31:0] ref_mem [1024];
  resp_t       exp_q [$];
  resp_t       got_q [$];
  int          gnt_cnt = 0;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
  end

  logic [31:0] m_off;
  logic        m_oob, m_vld, m_gnt;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_d;
  logic        prev_e;
  resp_t       m_r;

  // Outstanding responses = model queue length; the grant rule and the
  // response order follow directly from that queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_gnt",    32'(gnt_o), 32'd0);
      chk("rst_ram_en", 32'(ram_en_o), 32'd0);
      chk("rst_valid",  32'(r_valid_o), 32'd0);
      chk("rst_rdata",  r_rdata_o, 32'd0);
      chk("rst_err",    32'(r_err_o), 32'd0);
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      m_off = addr - BASE;
      m_oob = (m_off >= 32'(NW));
      m_vld = (exp_q.size() != 0);
      m_gnt = req && (exp_q.size() < 2 || (m_vld && r_ready));
      chk("gnt",    32'(gnt_o), 32'(m_gnt));
      chk("ram_en", 32'(ram_en_o), 32'(m_gnt && !m_oob));
      if (ram_en_o) chk("ram_addr", 32'(ram_addr_o), 32'(m_off[11:0]));
      chk("r_valid", 32'(r_valid_o), 32'(m_vld));
      if (m_vld) begin
        chk("r_rdata", r_rdata_o, exp_q[0].d);
        chk("r_err",   32'(r_err_o), 32'(exp_q[0].e));
      end
      if (stall_prev) begin
        chk("hold_rdata", r_rdata_o, prev_d);
        chk("hold_err",   32'(r_err_o), 32'(prev_e));
      end
      stall_prev = r_valid_o && !r_ready;
      prev_d = r_rdata_o;
      prev_e = r_err_o;
      if (m_vld && r_ready) begin
        got_q.push_back('{d: r_rdata_o, e: r_err_o});
        void'(exp_q.pop_front());
      end
      if (gnt_o) begin
        gnt_cnt++;
        if (m_oob) begin
          m_r = '{d: 32'd0, e: 1'b1};
        end else if (we) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[m_off[11:2]][8*b +: 8] = wdata[8*b +: 8];
          m_r = '{d: 32'd0, e: 1'b0};
        end else begin
          m_r = '{d: ref_mem[m_off[11:2]], e: 1'b0};
        end
        exp_q.push_back(m_r);
      end
    end
  end

  // ---------------- stimulus helpers (entered/left at posedge+1) ----------------
  task automatic send(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
    int k = 0;
    addr = a; we = w; be = b; wdata = d; req = 1'b1;
    forever begin
      @(negedge clk);
      if (gnt_o) break;
      k++;
      if (k > 50) begin
        n_chk++; n_fail++;
        $display("FAIL grant_timeout: no grant for addr %h", a);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int k = 0;
    req = 1'b0;
    r_ready = 1'b1;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk); #1; k++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
    end
  endtask

  int base, g0, e0;

  initial begin
    // Reset with a request present: grant must stay low.
    req = 1'b1;
    addr = BASE;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_gnt_gated", 32'(gnt_o), 32'd0);
    chk("reset_valid", 32'(r_valid_o), 32'd0);
    rst_n = 1'b1; req = 1'b0; r_ready = 1'b1;
    idle(2);

    // Write then read, back to back.
    base = got_q.size();
    send(BASE + 8, 1'b1, 4'hF, 32'hDEAD_BEEF);
    send(BASE + 8, 1'b0, 4'hF, 32'h0);
    req = 1'b0;
    @(negedge clk); #1;
    chk("rd_latency_valid", 32'(r_valid_o), 32'd1);
    chk("rd_latency_data",  r_rdata_o, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    drain();
    chk("wr_resp_data", got_q[base].d, 32'd0);
    chk("rd_resp_data", got_q[base+1].d, 32'hDEAD_BEEF);
    chk("rd_resp_err",  32'(got_q[base+1].e), 32'd0);

    // Partial byte-enable write.
    base = got_q.size();
    send(BASE + 8, 1'b1, 4'b0101, 32'h1122_3344);
    send(BASE + 8, 1'b0, 4'hF, 32'h0);
    drain();
    chk("be_merge", got_q[base+1].d, 32'hDE22_BE44);

    // Backpressure: four reads against a stalled consumer.
    for (int i = 0; i < 4; i++) send(BASE + 32'h10 + 4*i, 1'b1, 4'hF, 32'hA0A0_0000 + i);
    drain();
    base = got_q.size();
    g0 = gnt_cnt;
    r_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(BASE + 32'h10 + 4*i, 1'b0, 4'hF, 32'h0);
      end
      begin
        repeat (6) @(negedge clk);
        #2;
        chk("bp_two_grants", 32'(gnt_cnt - g0), 32'd2);
        chk("bp_gnt_low",    32'(gnt_o), 32'd0);
        chk("bp_valid_held", 32'(r_valid_o), 32'd1);
        chk("bp_head_data",  r_rdata_o, 32'hA0A0_0000);
        @(posedge clk); #1;
        r_ready = 1'b1;
      end
    join
    drain();
    chk("bp_total_grants", 32'(gnt_cnt - g0), 32'd4);
    for (int i = 0; i < 4; i++) chk("bp_order", got_q[base+i].d, 32'hA0A0_0000 + 32'(i));

    // Window boundaries.
    base = got_q.size();
    e0 = en_cnt;
    send(BASE + NW, 1'b0, 4'hF, 32'h0);
    send(BASE - 4,  1'b0, 4'hF, 32'h0);
    idle(1);
    chk("oob_no_ram_en", 32'(en_cnt - e0), 32'd0);
    send(BASE + NW - 4, 1'b0, 4'hF, 32'h0);
    send(BASE + NW - 1, 1'b0, 4'hF, 32'h0);
    drain();
    chk("oob_high_err",  32'(got_q[base].e), 32'd1);
    chk("oob_high_data", got_q[base].d, 32'd0);
    chk("oob_low_err",   32'(got_q[base+1].e), 32'd1);
    chk("last_word_err", 32'(got_q[base+2].e), 32'd0);
    chk("last_byte_err", 32'(got_q[base+3].e), 32'd0);
    chk("inrange_ram_en", 32'(en_cnt - e0), 32'd2);

    // Reset with two responses queued.
    r_ready = 1'b0;
    send(BASE + 8, 1'b0, 4'hF, 32'h0);
    send(BASE + 8, 1'b0, 4'hF, 32'h0);
    base = got_q.size();
    rst_n = 1'b0;
    req = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(r_valid_o), 32'd0);
    chk("mid_rst_gnt",   32'(gnt_o), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    r_ready = 1'b1;
    idle(4);
    chk("no_stale_resp", 32'(got_q.size() - base), 32'd0);
    send(BASE + 8, 1'b0, 4'hF, 32'h0);
    drain();
    chk("post_rst_count", 32'(got_q.size() - base), 32'd1);
    chk("post_rst_data",  got_q[base].d, 32'hDE22_BE44);

    // Random traffic against the reference memory.
    for (int i = 0; i < 10000; i++) begin
      req     = ($urandom_range(0, 3) != 0);
      we      = $urandom_range(0, 1) != 0;
      be      = 4'($urandom);
      wdata   = $urandom;
      r_ready = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 7))
        0:       addr = BASE + NW + 32'($urandom_range(0, 255));
        1:       addr = BASE - 32'($urandom_range(1, 64));
        default: addr = BASE + 32'($urandom_range(0, 63) * 4);
      endcase
      @(posedge clk); #1;
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sp_ram_req_bridge.md
# sp_ram_req_bridge

Request/grant front-end that sits directly upstream of the single-port data RAM (`sp_ram`) and converts a core-style data port into RAM strobes. Every accepted transaction returns exactly one in-order response through a ready/valid channel, and read data is held across response backpressure. Each request is range-checked against the RAM window; out-of-window requests never reach the RAM and return an error response instead.

## Interface
Parameters:
- `ADDR_WIDTH`, default 12: RAM byte-address width; drives `ram_addr_o`.
- `DATA_WIDTH`, default 32: data width; a multiple of 8.
- `NUM_WORDS`, default 4096: RAM size in bytes, the same value passed to the RAM's `NUM_WORDS`. Must be ≤ 2^ADDR_WIDTH.
- `BASE_ADDR`, default 32'h0010_0000: byte address of RAM offset 0.

Ports:
- `clk`, in, 1: the only clock; all state changes on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_i`, in, 1: request valid.
- `gnt_o`, out, 1: request accepted this cycle; combinational.
- `addr_i`, in, 32: byte address.
- `we_i`, in, 1: 1 = write, 0 = read.
- `be_i`, in, DATA_WIDTH/8: byte enables.
- `wdata_i`, in, DATA_WIDTH: write data.
- `r_valid_o`, out, 1: response valid.
- `r_ready_i`, in, 1: response consumer ready.
- `r_rdata_o`, out, DATA_WIDTH: read data; 0 for writes and errors.
- `r_err_o`, out, 1: request was outside the RAM window.
- `ram_en_o`, out, 1: RAM enable.
- `ram_addr_o`, out, ADDR_WIDTH: RAM byte address.
- `ram_we_o`, out, 1: RAM write enable.
- `ram_be_o`, out, DATA_WIDTH/8: RAM byte enables.
- `ram_wdata_o`, out, DATA_WIDTH: RAM write data.
- `ram_rdata_i`, in, DATA_WIDTH: RAM read data, registered by the RAM and valid one cycle after `ram_en_o`.

## Operation
Address decode:
- `off = addr_i - BASE_ADDR`, computed 32-bit unsigned; wraps modulo 2^32.
- `oob = (off >= NUM_WORDS)`.

RAM drive (all combinational):
- `ram_addr_o = off[ADDR_WIDTH-1:0]`.
- `ram_we_o = we_i`, `ram_be_o = be_i`, `ram_wdata_o = wdata_i`.
- `ram_en_o = gnt_o & ~oob`.

Credit:
- `occ = fifo_cnt + pend_q`, range 0..2.
- `pop = r_valid_o & r_ready_i`.
- `gnt_o = req_i & ((occ < 2) | pop)`.

Issue stage:
- On grant, at the next edge: `pend_q` ← 1, `pend_we_q` ← `we_i`, `pend_err_q` ← `oob`.
- With no grant, `pend_q` ← 0.

Response stage: a 2-entry FIFO of {`rdata`, `err`}.
- Pending beat value:
  - `rdata = (pend_we_q | pend_err_q) ? 0 : ram_rdata_i`.
  - `err = pend_err_q`.
- Output selection:
  - FIFO non-empty: `r_valid_o` = 1 and outputs come from the FIFO head.
  - FIFO empty and `pend_q` = 1: outputs come directly from the pending beat (bypass).
  - Otherwise `r_valid_o` = 0.
- Push rule: the pending beat is pushed at the edge unless it is consumed by bypass that cycle, i.e. unless FIFO is empty and `r_ready_i` = 1.
- Ordering: FIFO pop and push may occur in the same cycle. Responses stay strictly in grant order.
- Outputs are stable while `r_valid_o & ~r_ready_i`.

## Timing
- Reset values: `r_valid_o` = 0, `r_err_o` = 0, `r_rdata_o` = 0, `pend_q` = 0, FIFO empty.
- While reset is asserted, `gnt_o` = 0 and `ram_en_o` = 0.
- Reset mid-operation discards pending and queued responses; none are ever delivered.
- Latency: grant in cycle T gives `r_valid_o` in cycle T+1 when the FIFO is empty, otherwise after the queued responses ahead of it.
- Throughput: one transaction per cycle while `r_ready_i` = 1.
- Backpressure: with `r_ready_i` = 0, at most 2 further grants are issued; after that `gnt_o` = 0 until a pop.
- Out-of-window requests: granted on the same credit rule as any other request; `ram_en_o` stays 0; response `r_err_o` = 1 with `rdata` = 0.
- Boundary addresses:
  - `addr_i = BASE_ADDR + NUM_WORDS - 1` is in range.
  - `addr_i = BASE_ADDR + NUM_WORDS` is out of range.
  - `addr_i < BASE_ADDR` wraps to a large `off` and is out of range.
- `req_i` = 0 never produces a response; `gnt_o` never asserts without `req_i`.

## Test plan
- Reset, then write 0xDEADBEEF with `be_i` = 4'hF at BASE_ADDR+8, then read the same address → `gnt_o` = 1 on both; read response in cycle T+1 carries 0xDEADBEEF with `r_err_o` = 0; write response carries `rdata` = 0.
- `be_i` = 4'b0101 write of 0x11223344 over 0xDEADBEEF, then read back → 0xDE22BE44.
- Hold `r_ready_i` = 0 and issue 4 back-to-back reads → exactly 2 grants, then `gnt_o` = 0 and `r_valid_o` held steady; release → the two responses arrive in order, then the remaining requests are granted.
- Read at BASE_ADDR+NUM_WORDS and at BASE_ADDR-4 → `ram_en_o` = 0 throughout; responses have `r_err_o` = 1 and `rdata` = 0. Read at BASE_ADDR+NUM_WORDS-4 → `r_err_o` = 0.
- Assert `rst_n` low while 2 responses are queued → `r_valid_o` = 0 immediately; after release no stale response appears and `gnt_o` follows `req_i`.
- Random reads and writes with random `r_ready_i` over 10k cycles against a reference memory model → every response matches and arrives in order, with `occ` ≤ 2 at all times.
